// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: shared types and defaults for the fetch-side PC sequencer.
// Holds the FSM state encoding, the next-PC mux select and the width/reset
// defaults used by pc_sequencer and pc_next_sel.
package pc_sequencer_pkg;

  localparam int          PC_W_DEF     = 16;
  localparam logic [15:0] RESET_PC_DEF = 16'h0000;

  // Instructions are two bytes wide, so sequential fetch steps the PC by this.
  localparam int          INSTR_BYTES  = 2;

  typedef enum logic [2:0] {
    ST_BOOT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_HOLD  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_HALT  = 3'd4
  } seq_state_e;

  typedef enum logic [1:0] {
    PC_SEL_HOLD = 2'd0,
    PC_SEL_INC  = 2'd1,
    PC_SEL_TGT  = 2'd2
  } pc_sel_e;

endpackage

// File: rtl/cla_16b.sv
// cla_16b: 16-bit two-level carry-lookahead adder.
// Four 4-bit groups produce group generate/propagate; a second lookahead level
// derives every group carry directly from c_in so no carry ripples between groups.
module cla_16b (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c_in,
  output logic [15:0] sum,
  output logic        c_out
);

  logic [15:0] g;
  logic [15:0] p;
  logic [3:0]  grp_g;
  logic [3:0]  grp_p;
  logic        c4;
  logic        c8;
  logic        c12;
  logic        c16;

  // Group generate/propagate packed as {G, P}.
  function automatic logic [1:0] grp_gp(input logic [3:0] g4, input logic [3:0] p4);
    logic gg;
    logic pp;
    gg = g4[3] | (p4[3] & g4[2]) | (p4[3] & p4[2] & g4[1]) |
         (p4[3] & p4[2] & p4[1] & g4[0]);
    pp = &p4;
    return {gg, pp};
  endfunction

  // Sum bits of one group with its internal carries looked ahead from cin.
  function automatic logic [3:0] grp_sum(input logic [3:0] g4, input logic [3:0] p4,
                                         input logic cin);
    logic c1;
    logic c2;
    logic c3;
    c1 = g4[0] | (p4[0] & cin);
    c2 = g4[1] | (p4[1] & g4[0]) | (p4[1] & p4[0] & cin);
    c3 = g4[2] | (p4[2] & g4[1]) | (p4[2] & p4[1] & g4[0]) |
         (p4[2] & p4[1] & p4[0] & cin);
    return p4 ^ {c3, c2, c1, cin};
  endfunction

  assign g = a & b;
  assign p = a ^ b;

  for (genvar i = 0; i < 4; i++) begin : g_grp
    assign {grp_g[i], grp_p[i]} = grp_gp(g[4*i +: 4], p[4*i +: 4]);
  end

  assign c4  = grp_g[0] | (grp_p[0] & c_in);
  assign c8  = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & c_in);
  assign c12 = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0]) |
               ((&grp_p[2:0]) & c_in);
  assign c16 = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1]) |
               (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0]) | ((&grp_p) & c_in);

  assign sum = {grp_sum(g[15:12], p[15:12], c12),
                grp_sum(g[11:8],  p[11:8],  c8),
                grp_sum(g[7:4],   p[7:4],   c4),
                grp_sum(g[3:0],   p[3:0],   c_in)};
  assign c_out = c16;

endmodule

// File: rtl/pc_next_sel.sv
// pc_next_sel: combinational next-PC selection (hold / +2 / redirect target)
// together with the two error terms the sequencer accumulates: carry out of the
// sequential increment and an odd (misaligned) redirect target.
module pc_next_sel
  import pc_sequencer_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
) (
  input  logic [PC_W-1:0] pc,
  input  pc_sel_e         sel,
  input  logic [PC_W-1:0] target,
  output logic [PC_W-1:0] pc_next,
  output logic [PC_W-1:0] pc_plus_two,
  output logic            ovf_err,
  output logic            misalign_err
);

  logic [PC_W-1:0] step;
  logic            inc_carry;

  assign step = PC_W'(INSTR_BYTES);

  cla_16b u_cla (
    .a     (pc),
    .b     (step),
    .c_in  (1'b0),
    .sum   (pc_plus_two),
    .c_out (inc_carry)
  );

  // Pick the next PC; error terms only count for the source actually selected.
  always_comb begin
    pc_next      = pc;
    ovf_err      = 1'b0;
    misalign_err = 1'b0;
    case (sel)
      PC_SEL_INC: begin
        pc_next = pc_plus_two;
        ovf_err = inc_carry;
      end
      PC_SEL_TGT: begin
        pc_next      = target;
        misalign_err = target[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the architectural PC, sequences instruction-memory fetches,
// applies branch/jump redirects with a one-cycle flush, and stops on HALT.
// Optional build macro PC_SEQ_PERF_CNT_EN adds saturating redirect and
// fetch-wait performance counters.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_done,
  input  logic            imem_stall,
  output logic            if_valid,
  output logic [PC_W-1:0] if_pc_plus_two,
  input  logic            stall_in,
  input  logic            br_valid,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  input  logic            halt,
  output logic            flush,
  output logic            halted,
  output logic            err
`ifdef PC_SEQ_PERF_CNT_EN
  ,
  output logic [15:0]     redirect_cnt,
  output logic [15:0]     fetch_wait_cnt
`endif
);

  seq_state_e      state_d, state_q;
  logic [PC_W-1:0] pc_d, pc_q;
  logic            err_d, err_q;
  logic            hold_vld_d, hold_vld_q;

  pc_sel_e         pc_sel;
  logic [PC_W-1:0] pc_plus_two;
  logic            ovf_err;
  logic            misalign_err;
  logic            redirect;
  logic            outstanding;

  // Progress is tracked purely by imem_done; the busy indication carries no extra information.
  logic            unused_imem_stall;
  assign unused_imem_stall = imem_stall;

  assign redirect    = br_valid & br_taken & (state_q != ST_HALT);
  assign outstanding = ((state_q == ST_FETCH) | (state_q == ST_DRAIN)) & ~imem_done;

  pc_next_sel #(.PC_W(PC_W)) u_pc_next_sel (
    .pc           (pc_q),
    .sel          (pc_sel),
    .target       (br_target),
    .pc_next      (pc_d),
    .pc_plus_two  (pc_plus_two),
    .ovf_err      (ovf_err),
    .misalign_err (misalign_err)
  );

  // Next-state, PC select and pulse outputs: redirect beats halt beats normal sequencing.
  always_comb begin
    state_d    = state_q;
    pc_sel     = PC_SEL_HOLD;
    hold_vld_d = hold_vld_q;
    if_valid   = 1'b0;
    flush      = 1'b0;
    if (redirect) begin
      flush      = 1'b1;
      pc_sel     = PC_SEL_TGT;
      hold_vld_d = 1'b0;
      state_d    = outstanding ? ST_DRAIN : ST_FETCH;
    end else if (halt) begin
      hold_vld_d = 1'b0;
      state_d    = ST_HALT;
    end else begin
      case (state_q)
        ST_BOOT: state_d = ST_FETCH;
        ST_FETCH: begin
          if (imem_done) begin
            if (!stall_in) begin
              if_valid = 1'b1;
              pc_sel   = PC_SEL_INC;
            end else begin
              hold_vld_d = 1'b1;
              state_d    = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (!stall_in) begin
            if (hold_vld_q) begin
              if_valid = 1'b1;
              pc_sel   = PC_SEL_INC;
            end
            hold_vld_d = 1'b0;
            state_d    = ST_FETCH;
          end
        end
        ST_DRAIN: begin
          if (imem_done) state_d = ST_FETCH;
        end
        ST_HALT: ;
        default: state_d = ST_BOOT;
      endcase
    end
  end

  // Error flag is sticky until reset.
  always_comb begin
    err_d = err_q | ovf_err | misalign_err;
  end

  // State, PC, buffer-valid and error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      err_q      <= 1'b0;
      hold_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      err_q      <= err_d;
      hold_vld_q <= hold_vld_d;
    end
  end

  assign imem_req       = (state_q == ST_FETCH);
  assign imem_addr      = pc_q;
  assign if_pc_plus_two = pc_plus_two;
  assign halted         = (state_q == ST_HALT);
  assign err            = err_q;

`ifdef PC_SEQ_PERF_CNT_EN
  logic [15:0] redirect_cnt_d, redirect_cnt_q;
  logic [15:0] fetch_wait_cnt_d, fetch_wait_cnt_q;

  // Saturating counts of flush cycles and of cycles spent waiting on memory.
  always_comb begin
    redirect_cnt_d   = redirect_cnt_q;
    fetch_wait_cnt_d = fetch_wait_cnt_q;
    if (flush && (redirect_cnt_q != 16'hFFFF))
      redirect_cnt_d = redirect_cnt_q + 16'd1;
    if (imem_req && !imem_done && (fetch_wait_cnt_q != 16'hFFFF))
      fetch_wait_cnt_d = fetch_wait_cnt_q + 16'd1;
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_cnt_q   <= 16'h0000;
      fetch_wait_cnt_q <= 16'h0000;
    end else begin
      redirect_cnt_q   <= redirect_cnt_d;
      fetch_wait_cnt_q <= fetch_wait_cnt_d;
    end
  end

  assign redirect_cnt   = redirect_cnt_q;
  assign fetch_wait_cnt = fetch_wait_cnt_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench for pc_sequencer. A behavioural model of the
// fetch rules predicts per-cycle control outputs and pushes every expected
// fetched instruction (PC+2) into a queue; a forked monitor pops on if_valid.
`timescale 1ns/1ps
module tb_pc_sequencer;

  localparam int PC_W = 16;

  logic            clk;
  logic            rst_n;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_done;
  logic            imem_stall;
  logic            if_valid;
  logic [PC_W-1:0] if_pc_plus_two;
  logic            stall_in;
  logic            br_valid;
  logic            br_taken;
  logic [PC_W-1:0] br_target;
  logic            halt;
  logic            flush;
  logic            halted;
  logic            err;
`ifdef PC_SEQ_PERF_CNT_EN
  logic [15:0]     redirect_cnt;
  logic [15:0]     fetch_wait_cnt;
`endif

  pc_sequencer #(.PC_W(PC_W), .RESET_PC(16'h0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_done      (imem_done),
    .imem_stall     (imem_stall),
    .if_valid       (if_valid),
    .if_pc_plus_two (if_pc_plus_two),
    .stall_in       (stall_in),
    .br_valid       (br_valid),
    .br_taken       (br_taken),
    .br_target      (br_target),
    .halt           (halt),
    .flush          (flush),
    .halted         (halted),
    .err            (err)
`ifdef PC_SEQ_PERF_CNT_EN
    ,
    .redirect_cnt   (redirect_cnt),
    .fetch_wait_cnt (fetch_wait_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  // Expected PC+2 of every instruction the model says is handed to IF/ID.
  logic [15:0] exp_q[$];

  // Reference model: architectural PC and what the fetch unit is currently doing.
  logic [15:0] m_pc;
  bit          m_boot;
  bit          m_halted;
  bit          m_draining;
  bit          m_buffered;
  bit          m_err;

  // Instruction-memory model: accepts a request, answers after a latency.
  bit          mem_busy;
  int          mem_left;
  int          mem_lat;
  bit          mem_rand;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply the fetch rules for one cycle: check outputs, log deliveries, advance.
  task automatic modelStep();
    bit exp_req;
    bit redir;
    bit deliver;
    exp_req = !(m_boot || m_halted || m_draining || m_buffered);
    redir   = br_valid && br_taken && !m_halted;
    checkOutput("imem_req", imem_req, exp_req);
    if (exp_req) checkOutput("imem_addr", imem_addr, m_pc);
    checkOutput("flush", flush, redir);
    checkOutput("halted", halted, m_halted);
    checkOutput("err", err, m_err);
    deliver = !redir && !halt && !m_halted && !stall_in &&
              ((exp_req && imem_done) || m_buffered);
    if (deliver) exp_q.push_back(16'(m_pc + 16'd2));
    if (redir) begin
      m_draining = (exp_req || m_draining) && !imem_done;
      m_pc       = br_target;
      if (br_target[0]) m_err = 1'b1;
      m_boot     = 1'b0;
      m_buffered = 1'b0;
    end else if (halt) begin
      m_halted   = 1'b1;
      m_boot     = 1'b0;
      m_buffered = 1'b0;
      m_draining = 1'b0;
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_draining) begin
      if (imem_done) m_draining = 1'b0;
    end else if (m_buffered) begin
      if (!stall_in) m_buffered = 1'b0;
    end else if (!m_halted && imem_done && stall_in) begin
      m_buffered = 1'b1;
    end
    if (deliver) begin
      if (m_pc == 16'hFFFE) m_err = 1'b1;
      m_pc = 16'(m_pc + 16'd2);
    end
  endtask

  // One clock cycle of stimulus: memory answers, drive inputs, then check and model.
  task automatic applyStimulus(input bit stl, input bit brv, input bit brt,
                               input logic [15:0] tgt, input bit hlt);
    @(negedge clk);
    if (imem_req && !mem_busy) begin
      mem_busy = 1'b1;
      mem_left = mem_rand ? int'($urandom_range(0, 3)) : mem_lat;
    end
    imem_done  = mem_busy && (mem_left == 0);
    imem_stall = mem_busy && !imem_done;
    stall_in   = stl;
    br_valid   = brv;
    br_taken   = brt;
    br_target  = tgt;
    halt       = hlt;
    #1;
    modelStep();
    if (imem_done) mem_busy = 1'b0;
    else if (mem_busy) mem_left--;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
  endtask

  // Assert reset asynchronously mid-cycle, check reset outputs, release after an edge.
  task automatic resetDut();
    @(negedge clk);
    stall_in   = 1'b0;
    br_valid   = 1'b0;
    br_taken   = 1'b0;
    br_target  = 16'h0000;
    halt       = 1'b0;
    imem_done  = 1'b0;
    imem_stall = 1'b0;
    rst_n      = 1'b0;
    #1;
    checkOutput("rst_imem_req", imem_req, 1'b0);
    checkOutput("rst_imem_addr", imem_addr, 16'h0000);
    checkOutput("rst_if_valid", if_valid, 1'b0);
    checkOutput("rst_flush", flush, 1'b0);
    checkOutput("rst_halted", halted, 1'b0);
    checkOutput("rst_err", err, 1'b0);
    mem_busy   = 1'b0;
    mem_left   = 0;
    m_pc       = 16'h0000;
    m_boot     = 1'b1;
    m_halted   = 1'b0;
    m_draining = 1'b0;
    m_buffered = 1'b0;
    m_err      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Scoreboard monitor: every if_valid pulse must match the oldest expected PC+2.
  task automatic runMonitor();
    logic [15:0] exp;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && (if_valid === 1'b1)) begin
        if (exp_q.size() == 0) begin
          checkOutput("if_valid_unexpected", if_valid, 1'b0);
        end else begin
          exp = exp_q.pop_front();
          checkOutput("if_pc_plus_two", if_pc_plus_two, exp);
        end
      end
    end
  endtask

  initial begin
    logic [15:0] tgt;
    int halt_age;
    n_checks   = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    stall_in   = 1'b0;
    br_valid   = 1'b0;
    br_taken   = 1'b0;
    br_target  = 16'h0000;
    halt       = 1'b0;
    imem_done  = 1'b0;
    imem_stall = 1'b0;
    mem_rand   = 1'b0;
    mem_lat    = 0;
    fork
      runMonitor();
    join_none

    $display("[TB] straight-line fetch");
    resetDut();
    idle(5);

    $display("[TB] decode stall while fetch completes at pc=4");
    resetDut();
    idle(3);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    idle(2);

    $display("[TB] redirect while a fetch is pending");
    mem_lat = 3;
    idle(1);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0040, 1'b0);
    idle(2);
    mem_lat = 0;
    idle(3);

    $display("[TB] redirect and halt together, then a lone halt");
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0100, 1'b1);
    idle(3);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0300, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
    idle(2);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0200, 1'b0);
    idle(2);

    $display("[TB] increment wrap and misaligned target");
    resetDut();
    idle(1);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'hFFFE, 1'b0);
    idle(4);
    resetDut();
    idle(1);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0013, 1'b0);
    idle(3);

    $display("[TB] reset while draining");
    resetDut();
    mem_lat = 3;
    idle(2);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0080, 1'b0);
    idle(1);
    resetDut();
    mem_lat = 0;
    idle(4);

    $display("[TB] randomized traffic");
    resetDut();
    mem_rand = 1'b1;
    halt_age = 0;
    for (int c = 0; c < 600; c++) begin
      tgt = 16'($urandom);
      if ($urandom_range(0, 7) != 0) tgt[0] = 1'b0;
      if ($urandom_range(0, 15) == 0) tgt = 16'hFFFC;
      applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                    $urandom_range(0, 1) == 1, tgt, $urandom_range(0, 49) == 0);
      if (m_halted) halt_age++;
      if (halt_age > 4) begin
        halt_age = 0;
        resetDut();
      end
    end

    #3;
    checkOutput("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
